// File: rtl/ifu_fetch_align_decompress.sv
// Fetch alignment queue: buffers fetch packets as 16-bit parcels, reassembles
// 32-bit instructions across packet boundaries and expands RVC parcels.
module ifu_fetch_align_decompress #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned FETCHW = 64,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              FlushD,
   input  logic              FetchValid,
   output logic              FetchReady,
   input  logic [FETCHW-1:0] FetchData,
   input  logic [XLEN-1:0]   FetchPC,
   output logic              InstrValidD,
   input  logic              InstrReadyD,
   output logic [31:0]       InstrD,
   output logic [XLEN-1:0]   InstrPCD,
   output logic              CompressedD,
   output logic              IllegalCompInstrD
);
   localparam int unsigned PW   = FETCHW / 16;     // parcels per packet
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned OW   = $clog2(PW);      // parcel offset bits of FetchPC
   localparam int unsigned CW   = AW + 1;
   localparam bit          RV64 = (XLEN == 64);

   logic [15:0]     mem_q [DEPTH];
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d, push_n;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            redir_q, redir_d;
   logic [OW-1:0]   off;
   logic [15:0]     p0, p1;
   logic            is32, push, pop;
   logic [32:0]     dec;

   // RVC expansion: returns {illegal, expanded instruction}
   function automatic logic [32:0] rvc_expand(input logic [15:0] c);
      logic [4:0]  rd, rs2, rdp, rs1p;
      logic [11:0] imm6;
      logic        ill;
      logic [31:0] o;
      rd   = c[11:7];
      rs2  = c[6:2];
      rdp  = {2'b01, c[4:2]};
      rs1p = {2'b01, c[9:7]};
      imm6 = {{7{c[12]}}, c[6:2]};
      ill  = 1'b0;
      o    = '0;
      case ({c[1:0], c[15:13]})
         5'b00_000: begin
            o   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
            ill = (c[12:5] == '0);
         end
         5'b00_001: o = {4'b0, c[6:5], c[12:10], 3'b000, rs1p, 3'b011, rdp, 7'h07};
         5'b00_010: o = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
         5'b00_011: o = RV64 ? {4'b0, c[6:5], c[12:10], 3'b000, rs1p, 3'b011, rdp, 7'h03}
                             : {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h07};
         5'b00_101: o = {4'b0, c[6:5], c[12], rdp, rs1p, 3'b011, c[11:10], 3'b000, 7'h27};
         5'b00_110: o = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
         5'b00_111: o = RV64 ? {4'b0, c[6:5], c[12], rdp, rs1p, 3'b011, c[11:10], 3'b000, 7'h23}
                             : {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h27};
         5'b01_000: o = {imm6, rd, 3'b000, rd, 7'h13};
         5'b01_001: begin
            if (RV64) begin
               o   = {imm6, rd, 3'b000, rd, 7'h1B};
               ill = (rd == '0);
            end else begin
               o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}}, 5'd1, 7'h6F};
            end
         end
         5'b01_010: o = {imm6, 5'd0, 3'b000, rd, 7'h13};
         5'b01_011: begin
            ill = ({c[12], c[6:2]} == '0);
            if (rd == 5'd2) o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
            else            o = {{15{c[12]}}, c[6:2], rd, 7'h37};
         end
         5'b01_100: begin
            case (c[11:10])
               2'b00: begin
                  o   = {6'b000000, c[12], c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                  ill = !RV64 && c[12];
               end
               2'b01: begin
                  o   = {6'b010000, c[12], c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                  ill = !RV64 && c[12];
               end
               2'b10: o = {imm6, rs1p, 3'b111, rs1p, 7'h13};
               default: begin
                  case ({c[12], c[6:5]})
                     3'b000: o = {7'h20, rdp, rs1p, 3'b000, rs1p, 7'h33};
                     3'b001: o = {7'h00, rdp, rs1p, 3'b100, rs1p, 7'h33};
                     3'b010: o = {7'h00, rdp, rs1p, 3'b110, rs1p, 7'h33};
                     3'b011: o = {7'h00, rdp, rs1p, 3'b111, rs1p, 7'h33};
                     3'b100: begin o = {7'h20, rdp, rs1p, 3'b000, rs1p, 7'h3B}; ill = !RV64; end
                     3'b101: begin o = {7'h00, rdp, rs1p, 3'b000, rs1p, 7'h3B}; ill = !RV64; end
                     default: ill = 1'b1;
                  endcase
               end
            endcase
         end
         5'b01_101: o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}}, 5'd0, 7'h6F};
         5'b01_110: o = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000, c[11:10], c[4:3], c[12], 7'h63};
         5'b01_111: o = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001, c[11:10], c[4:3], c[12], 7'h63};
         5'b10_000: begin
            o   = {6'b000000, c[12], c[6:2], rd, 3'b001, rd, 7'h13};
            ill = !RV64 && c[12];
         end
         5'b10_001: o = {3'b0, c[4:2], c[12], c[6:5], 3'b000, 5'd2, 3'b011, rd, 7'h07};
         5'b10_010: begin
            o   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
            ill = (rd == '0);
         end
         5'b10_011: begin
            if (RV64) begin
               o   = {3'b0, c[4:2], c[12], c[6:5], 3'b000, 5'd2, 3'b011, rd, 7'h03};
               ill = (rd == '0);
            end else begin
               o = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h07};
            end
         end
         5'b10_100: begin
            if (!c[12]) begin
               if (rs2 == '0) begin
                  o   = {12'b0, rd, 3'b000, 5'd0, 7'h67};
                  ill = (rd == '0);
               end else begin
                  o = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
               end
            end else if (rs2 == '0) begin
               o = (rd == '0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, 7'h67};
            end else begin
               o = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
            end
         end
         5'b10_101: o = {3'b0, c[9:7], c[12], rs2, 5'd2, 3'b011, c[11:10], 3'b000, 7'h27};
         5'b10_110: o = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
         5'b10_111: o = RV64 ? {3'b0, c[9:7], c[12], rs2, 5'd2, 3'b011, c[11:10], 3'b000, 7'h23}
                             : {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h27};
         default:   ill = 1'b1;
      endcase
      return {ill, o};
   endfunction

   assign off        = redir_q ? FetchPC[OW:1] : '0;
   assign push_n     = CW'(PW) - CW'(off);
   assign FetchReady = reset_n && ((CW'(DEPTH) - count_q) >= CW'(PW));
   assign push       = FetchValid && FetchReady && !FlushD;
   assign pop        = InstrValidD && InstrReadyD && !FlushD;
   assign p0         = mem_q[head_q];
   assign p1         = mem_q[head_q + AW'(1)];
   assign InstrPCD   = pc_q;

   // Head decode: valid only once the whole instruction is buffered
   always_comb begin
      dec               = rvc_expand(p0);
      is32              = (p0[1:0] == 2'b11);
      InstrValidD       = (count_q != '0) && (!is32 || (count_q >= CW'(2)));
      InstrD            = '0;
      CompressedD       = 1'b0;
      IllegalCompInstrD = 1'b0;
      if (InstrValidD) begin
         if (is32) begin
            InstrD = {p1, p0};
         end else begin
            CompressedD       = 1'b1;
            IllegalCompInstrD = dec[32];
            InstrD            = dec[32] ? {16'b0, p0} : dec[31:0];
         end
      end
   end

   // Pointer, count and PC bookkeeping; flush overrides push and pop
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pc_d    = pc_q;
      redir_d = redir_q;
      if (FlushD) begin
         count_d = '0;
         head_d  = tail_q;
         redir_d = 1'b1;
      end else begin
         if (push) begin
            tail_d  = tail_q + AW'(push_n);
            count_d = count_d + push_n;
            if (redir_q) begin
               pc_d    = FetchPC;
               redir_d = 1'b0;
            end
         end
         // Redirect implies an empty queue, so a pop never races the PC load
         if (pop) begin
            head_d  = head_q + (is32 ? AW'(2) : AW'(1));
            count_d = count_d - (is32 ? CW'(2) : CW'(1));
            pc_d    = pc_q + (is32 ? XLEN'(4) : XLEN'(2));
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pc_q    <= '0;
         redir_q <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
      end
   end

   // Parcel storage: packet parcels from the redirect offset onward land at tail
   always_ff @(posedge clk) begin
      if (push) begin
         for (int unsigned i = 0; i < PW; i++) begin
            if (i >= 32'(off)) mem_q[tail_q + AW'(i) - AW'(off)] <= FetchData[16*i +: 16];
         end
      end
   end
endmodule
